paddle_motion_ctrl: RTL and testbench

//  Owns the vertical position of one Pong paddle. Each move tick it picks one request source:
//   the AI up/down pair or the player buttons. It steps paddle_y with a speed ramp and clamps
//   it to the playfield. Sits between ai_player / button synchronisers and the draw/collision

---
 rtl/pong_pkg.sv | 11 +
 rtl/pong_tick_div.sv | 27 ++
 rtl/paddle_motion_ctrl.sv | 130 +++++++++++++
 tb/tb_paddle_motion_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong playfield constants and paddle/ball FSM types.
package pong_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned PADDLE_H = 16;

  typedef enum logic [1:0] {IDLE, ACCEL, CRUISE} paddle_state_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

endpackage

// File: rtl/pong_tick_div.sv
// Free-running move-tick divider; tick is high for the last cycle of each period.
module pong_tick_div #(
  parameter int unsigned TICK_DIV = 833334
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] div_cnt;

  assign tick = (div_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
    end else if (clear || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/paddle_motion_ctrl.sv
// Vertical paddle mover: per-tick source select, speed ramp FSM and playfield clamp.
module paddle_motion_ctrl #(
  parameter int unsigned TICK_DIV   = 833334,
  parameter int unsigned SCREEN_H   = 120,
  parameter int unsigned PADDLE_H   = 16,
  parameter int unsigned MAX_STEP   = 3,
  parameter int unsigned RAMP_TICKS = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ai_enable,
  input  logic       ai_up,
  input  logic       ai_down,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       freeze,
  input  logic       recentre,
  output logic [7:0] paddle_y,
  output logic       moving,
  output logic       at_top,
  output logic       at_bottom,
  output logic       step_pulse
);
  import pong_pkg::*;

  localparam int unsigned Y_MAX  = SCREEN_H - PADDLE_H;
  localparam int unsigned Y_MID  = Y_MAX / 2;
  localparam int unsigned STEP_W = 3;
  localparam int unsigned RAMP_W = (RAMP_TICKS > 2) ? $clog2(RAMP_TICKS) : 1;

  paddle_state_t     state, state_n;
  dir_t              dir, dir_n, req_dir;
  logic [STEP_W-1:0] step, step_n;
  logic [RAMP_W-1:0] ramp_cnt, ramp_n;
  logic [7:0]        y_n;
  logic [8:0]        y_wide, y_sum;
  logic              pulse_n, do_move, tick;
  logic              req_up, req_down, req_valid;

  pong_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
    .clk    (clk),
    .resetn (resetn),
    .clear  (recentre),
    .tick   (tick)
  );

  // Exactly one of up/down is a request; both or neither means no request.
  assign req_up    = ai_enable ? ai_up   : btn_up;
  assign req_down  = ai_enable ? ai_down : btn_down;
  assign req_valid = req_up ^ req_down;
  assign req_dir   = req_up ? DIR_UP : DIR_DOWN;

  assign moving    = (state != IDLE);
  assign at_top    = (paddle_y == 8'd0);
  assign at_bottom = (paddle_y == 8'(Y_MAX));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      dir        <= DIR_UP;
      step       <= '0;
      ramp_cnt   <= '0;
      paddle_y   <= 8'(Y_MID);
      step_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      dir        <= dir_n;
      step       <= step_n;
      ramp_cnt   <= ramp_n;
      paddle_y   <= y_n;
      step_pulse <= pulse_n;
    end
  end

  always_comb begin
    state_n = state;
    dir_n   = dir;
    step_n  = step;
    ramp_n  = ramp_cnt;
    y_n     = paddle_y;
    pulse_n = 1'b0;
    do_move = 1'b0;
    y_wide  = {1'b0, paddle_y};
    y_sum   = y_wide;

    if (recentre) begin
      state_n = IDLE;
      step_n  = '0;
      ramp_n  = '0;
      y_n     = 8'(Y_MID);
    end else if (tick) begin
      if (freeze || !req_valid) begin
        state_n = IDLE;
        step_n  = '0;
        ramp_n  = '0;
      end else if (state == IDLE || req_dir != dir) begin
        state_n = ACCEL;
        dir_n   = req_dir;
        step_n  = STEP_W'(1);
        ramp_n  = '0;
        do_move = 1'b1;
      end else if (state == ACCEL) begin
        if (ramp_cnt == RAMP_W'(RAMP_TICKS - 1)) begin
          ramp_n = '0;
          if (step < STEP_W'(MAX_STEP)) step_n = step + STEP_W'(1);
        end else begin
          ramp_n = ramp_cnt + RAMP_W'(1);
        end
        if (step_n >= STEP_W'(MAX_STEP)) state_n = CRUISE;
        do_move = 1'b1;
      end else begin
        step_n  = STEP_W'(MAX_STEP);
        do_move = 1'b1;
      end
    end

    // Clamped move in 9 bits so neither direction can wrap.
    if (do_move) begin
      if (dir_n == DIR_UP) begin
        y_sum = (y_wide < 9'(step_n)) ? 9'd0 : y_wide - 9'(step_n);
      end else begin
        y_sum = y_wide + 9'(step_n);
        if (y_sum > 9'(Y_MAX)) y_sum = 9'(Y_MAX);
      end
      y_n     = y_sum[7:0];
      pulse_n = (y_n != paddle_y);
    end
  end

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Directed bench for paddle_motion_ctrl with a 4-cycle move tick.
module tb_paddle_motion_ctrl;

  logic       clk = 1'b0;
  logic       resetn, ai_enable, ai_up, ai_down, btn_up, btn_down, freeze, recentre;
  logic [7:0] paddle_y;
  logic       moving, at_top, at_bottom, step_pulse;
  int         checks = 0;
  int         passed = 0;
  int         fails  = 0;
  int         exp_y;

  paddle_motion_ctrl #(
    .TICK_DIV(4), .SCREEN_H(120), .PADDLE_H(16), .MAX_STEP(3), .RAMP_TICKS(2)
  ) dut (
    .clk(clk), .resetn(resetn), .ai_enable(ai_enable), .ai_up(ai_up), .ai_down(ai_down),
    .btn_up(btn_up), .btn_down(btn_down), .freeze(freeze), .recentre(recentre),
    .paddle_y(paddle_y), .moving(moving), .at_top(at_top), .at_bottom(at_bottom),
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse recentre for one edge; the tick counter restarts from 0 afterwards.
  task automatic do_recentre();
    recentre = 1'b1;
    @(posedge clk); #1;
    recentre = 1'b0;
  endtask

  // One full tick period: pulse must be low before the move, then check the landed value.
  task automatic tick_chk(input string tag, input int ey, input logic ep, input logic em);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_pre_pulse"}, 32'(step_pulse), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_y"}, 32'(paddle_y), 32'(ey));
    chk({tag, "_pulse"}, 32'(step_pulse), 32'(ep));
    chk({tag, "_moving"}, 32'(moving), 32'(em));
  endtask

  initial begin
    int t2[7];
    int t5[5];
    t2 = '{53, 54, 56, 58, 61, 64, 67};
    t5 = '{2, 4, 6, 9, 12};
    resetn = 1'b0; ai_enable = 1'b0; ai_up = 1'b0; ai_down = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; freeze = 1'b0; recentre = 1'b0;
    #23 resetn = 1'b1;

    // 1: idle after reset
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("t1_pulse", 32'(step_pulse), 32'd0);
    end
    chk("t1_y", 32'(paddle_y), 32'd52);
    chk("t1_moving", 32'(moving), 32'd0);
    chk("t1_at_top", 32'(at_top), 32'd0);
    chk("t1_at_bottom", 32'(at_bottom), 32'd0);

    // 2: button ramp down, then clamp at bottom
    do_recentre();
    btn_down = 1'b1;
    for (int i = 0; i < 7; i++) tick_chk("t2_ramp", t2[i], 1'b1, 1'b1);
    exp_y = 67;
    for (int i = 0; i < 12; i++) begin
      exp_y += 3;
      tick_chk("t2_cruise", exp_y, 1'b1, 1'b1);
    end
    tick_chk("t2_clamp", 104, 1'b1, 1'b1);
    chk("t2_at_bottom", 32'(at_bottom), 32'd1);
    tick_chk("t2_hold", 104, 1'b0, 1'b1);

    // 3: AI up from 53 into cruise, clamp at top, release to idle
    do_recentre();
    tick_chk("t3_first", 53, 1'b1, 1'b1);
    btn_down = 1'b0; ai_enable = 1'b1; ai_up = 1'b1;
    tick_chk("t3_flip", 52, 1'b1, 1'b1);
    tick_chk("t3_r1", 51, 1'b1, 1'b1);
    tick_chk("t3_r2", 49, 1'b1, 1'b1);
    tick_chk("t3_r3", 47, 1'b1, 1'b1);
    tick_chk("t3_r4", 44, 1'b1, 1'b1);
    exp_y = 44;
    for (int i = 0; i < 14; i++) begin
      exp_y -= 3;
      tick_chk("t3_cruise", exp_y, 1'b1, 1'b1);
    end
    tick_chk("t3_clamp", 0, 1'b1, 1'b1);
    chk("t3_at_top", 32'(at_top), 32'd1);
    tick_chk("t3_hold1", 0, 1'b0, 1'b1);
    tick_chk("t3_hold2", 0, 1'b0, 1'b1);
    ai_up = 1'b0;
    tick_chk("t3_release", 0, 1'b0, 1'b0);

    // 4: both buttons is no request; AI source ignores buttons
    ai_enable = 1'b0; btn_up = 1'b1; btn_down = 1'b1;
    tick_chk("t4_both", 0, 1'b0, 1'b0);
    ai_enable = 1'b1; ai_down = 1'b1;
    tick_chk("t4_ai", 1, 1'b1, 1'b1);
    chk("t4_at_top", 32'(at_top), 32'd0);

    // 5: cruise down, flip up restarts at step 1 in ACCEL
    for (int i = 0; i < 5; i++) tick_chk("t5_down", t5[i], 1'b1, 1'b1);
    ai_down = 1'b0; ai_up = 1'b1;
    tick_chk("t5_flip", 11, 1'b1, 1'b1);
    tick_chk("t5_accel1", 10, 1'b1, 1'b1);
    tick_chk("t5_accel2", 8, 1'b1, 1'b1);

    // 6: freeze, then walk to 90 and recentre on a tick; async reset mid-cruise
    freeze = 1'b1;
    tick_chk("t6_freeze", 8, 1'b0, 1'b0);
    freeze = 1'b0;
    tick_chk("t6_up1", 7, 1'b1, 1'b1);
    tick_chk("t6_up2", 6, 1'b1, 1'b1);
    freeze = 1'b1;
    tick_chk("t6_freeze2", 6, 1'b0, 1'b0);
    freeze = 1'b0; ai_up = 1'b0; ai_down = 1'b1;
    tick_chk("t6_d1", 7, 1'b1, 1'b1);
    tick_chk("t6_d2", 8, 1'b1, 1'b1);
    tick_chk("t6_d3", 10, 1'b1, 1'b1);
    tick_chk("t6_d4", 12, 1'b1, 1'b1);
    tick_chk("t6_d5", 15, 1'b1, 1'b1);
    exp_y = 15;
    for (int i = 0; i < 25; i++) begin
      exp_y += 3;
      tick_chk("t6_cruise", exp_y, 1'b1, 1'b1);
    end
    repeat (3) @(posedge clk);
    #1 recentre = 1'b1;
    @(posedge clk); #1;
    recentre = 1'b0;
    chk("t6_rc_y", 32'(paddle_y), 32'd52);
    chk("t6_rc_moving", 32'(moving), 32'd0);
    chk("t6_rc_pulse", 32'(step_pulse), 32'd0);
    tick_chk("t6_rc_next", 53, 1'b1, 1'b1);
    tick_chk("t6_b1", 54, 1'b1, 1'b1);
    tick_chk("t6_b2", 56, 1'b1, 1'b1);
    tick_chk("t6_b3", 58, 1'b1, 1'b1);
    tick_chk("t6_b4", 61, 1'b1, 1'b1);
    tick_chk("t6_b5", 64, 1'b1, 1'b1);
    #1 resetn = 1'b0;
    #1;
    chk("t6_rst_y", 32'(paddle_y), 32'd52);
    chk("t6_rst_moving", 32'(moving), 32'd0);
    chk("t6_rst_pulse", 32'(step_pulse), 32'd0);
    #10 resetn = 1'b1;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
